// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared widths, ALU opcodes, immediate modes and fill states
package alu_operand_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPW_DEF  = 4;
    localparam int RW_DEF   = 4;
    localparam int IMMW_DEF = 18;

    // SimpleRISC ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_MOV  = 4'hA;

    // Immediate modifier encodings; 2'b11 behaves like sign extension
    typedef enum logic [1:0] {
        IMM_SEXT     = 2'b00,
        IMM_ZEXT     = 2'b01,
        IMM_HI       = 2'b10,
        IMM_SEXT_ALT = 2'b11
    } imm_mod_e;

    // Occupancy of the main/skid pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } fill_state_e;

endpackage

// File: rtl/alu_imm_extend.sv
// rtl/alu_imm_extend.sv - combinational immediate extender (sign, zero, high-half)
module alu_imm_extend
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int IMMW = IMMW_DEF
) (
    input  logic [IMMW-1:0] imm_i,
    input  logic [1:0]      mod_i,
    output logic [XLEN-1:0] ext_o
);

    localparam int HW = XLEN / 2;

    // Select the extension form; the unused encoding falls back to sign extension
    always_comb begin
        ext_o = '0;
        case (imm_mod_e'(mod_i))
            IMM_ZEXT: ext_o = {{(XLEN-IMMW){1'b0}}, imm_i};
            IMM_HI:   ext_o = {imm_i[HW-1:0], {HW{1'b0}}};
            default:  ext_o = {{(XLEN-IMMW){imm_i[IMMW-1]}}, imm_i};
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage with 2-entry skid buffer; ALU_OPSTAGE_FWD_EN enables writeback forwarding
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF,
    parameter int RW   = RW_DEF,
    parameter int IMMW = IMMW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [RW-1:0]   in_rd,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic            in_use_imm,
    input  logic [IMMW-1:0] in_imm,
    input  logic [1:0]      in_imm_mod,
    input  logic            fwd_valid,
    input  logic [RW-1:0]   fwd_rd,
    input  logic [XLEN-1:0] fwd_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  out_op,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [RW-1:0]   out_rd
);

    // One buffered instruction; source indices are kept so held operands can still be patched
    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic            use_rs2;
    } entry_t;

    fill_state_e     state_q, state_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] imm_ext;
    entry_t          in_entry;
    entry_t          in_fwd, main_fwd, skid_fwd;
    logic            accept, drain;

    alu_imm_extend #(
        .XLEN (XLEN),
        .IMMW (IMMW)
    ) u_imm_extend (
        .imm_i (in_imm),
        .mod_i (in_imm_mod),
        .ext_o (imm_ext)
    );

    // Assemble the incoming instruction into entry form
    always_comb begin
        in_entry         = '0;
        in_entry.op      = in_op;
        in_entry.rd      = in_rd;
        in_entry.a       = in_rs1_val;
        in_entry.b       = in_use_imm ? imm_ext : in_rs2_val;
        in_entry.rs1     = in_rs1;
        in_entry.rs2     = in_rs2;
        in_entry.use_rs2 = !in_use_imm;
    end

`ifdef ALU_OPSTAGE_FWD_EN
    // Replace operands whose source register is being written back this cycle
    function automatic entry_t fwd_patch(input entry_t e, input logic fv,
                                         input logic [RW-1:0] frd, input logic [XLEN-1:0] fval);
        entry_t r;
        r = e;
        if (fv && (frd == e.rs1)) begin
            r.a = fval;
        end
        if (fv && e.use_rs2 && (frd == e.rs2)) begin
            r.b = fval;
        end
        return r;
    endfunction

    assign in_fwd   = fwd_patch(in_entry, fwd_valid, fwd_rd, fwd_val);
    assign main_fwd = fwd_patch(main_q,   fwd_valid, fwd_rd, fwd_val);
    assign skid_fwd = fwd_patch(skid_q,   fwd_valid, fwd_rd, fwd_val);
`else
    // Without forwarding the writeback bus is present but has no effect
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_val};
    assign in_fwd     = in_entry;
    assign main_fwd   = main_q;
    assign skid_fwd   = skid_q;
`endif

    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != ST_EMPTY) && out_ready;

    // Occupancy FSM and entry steering; held entries pick up forwarded values, flush empties both
    always_comb begin
        state_d = state_q;
        main_d  = main_fwd;
        skid_d  = skid_fwd;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_fwd;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = in_fwd;
                end else if (accept) begin
                    skid_d  = in_fwd;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_d  = skid_fwd;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // State, entry and registered ready; reset discards everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_op    = main_q.op;
    assign out_rd    = main_q.rd;
    assign out_a     = main_q.a;
    assign out_b     = main_q.b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

`ifdef ALU_OPSTAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        in_use_imm;
    logic [17:0] in_imm;
    logic [1:0]  in_imm_mod;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_rd;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_imm_mod (in_imm_mod),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_val    (fwd_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output scoreboard: a handshake seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got op=%h rd=%h a=%h b=%h, required no output", out_op, out_rd, out_a, out_b);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({out_op, out_rd, out_a, out_b} !== e) begin
                    errors++;
                    $display("FAIL sb_out got op=%h rd=%h a=%h b=%h, required op=%h rd=%h a=%h b=%h",
                             out_op, out_rd, out_a, out_b, e.op, e.rd, e.a, e.b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
                         input logic ui, input logic [17:0] imm, input logic [1:0] mod);
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rs1_val = v1;
        in_rs2_val = v2;
        in_use_imm = ui;
        in_imm     = imm;
        in_imm_mod = mod;
        in_valid   = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
                        input logic ui, input logic [17:0] imm, input logic [1:0] mod,
                        input logic [31:0] ea, input logic [31:0] eb);
        int n;
        n = 0;
        drive(op, rd, rs1, rs2, v1, v2, ui, imm, mod);
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout in_ready=%b, required 1", in_ready);
        end else begin
            exp_q.push_back('{op: op, rd: rd, a: ea, b: eb});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fwd_valid = 1'b0;
        fwd_rd = '0; fwd_val = '0;
        drive(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 18'h0, 2'b00);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b, required 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b, required 0", out_valid); end
        checks++;
        if ({out_op, out_rd, out_a, out_b} !== 72'h0) begin
            errors++;
            $display("FAIL reset_outputs got op=%h rd=%h a=%h b=%h, required all 0", out_op, out_rd, out_a, out_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(ALU_ADD, 4'd1, 4'd2, 4'd0, 32'd5, 32'd0, 1'b1, 18'h3FFFD, 2'b00, 32'd5, 32'hFFFFFFFD);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'd5 || out_b !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL basic_latency got v=%b a=%h b=%h, required v=1 a=00000005 b=fffffffd", out_valid, out_a, out_b);
        end
        wait_drain("basic");
    endtask

    task automatic test_imm_modes();
        logic [17:0] imms [6] = '{18'h01234, 18'h3FFFF, 18'h20000, 18'h1FFFF, 18'h3FFFF, 18'h00000};
        logic [1:0]  mods [6] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
        logic [31:0] expb [6] = '{32'h12340000, 32'h0003FFFF, 32'hFFFE0000, 32'h0001FFFF, 32'hFFFFFFFF, 32'hDEADBEEF};
        logic        uis  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(4'(i), 4'(i + 2), 4'd1, 4'd2, 32'(i) * 32'h11111111, 32'hDEADBEEF,
                 uis[i], imms[i], mods[i], 32'(i) * 32'h11111111, expb[i]);
        end
        wait_drain("imm");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(ALU_SUB, 4'd3, 4'd1, 4'd2, 32'hA0, 32'hA1, 1'b0, 18'h0, 2'b00);
        exp_q.push_back('{op: ALU_SUB, rd: 4'd3, a: 32'hA0, b: 32'hA1});
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_1 got %b, required 1", in_ready); end
        drive(ALU_XOR, 4'd4, 4'd1, 4'd2, 32'hB0, 32'hB1, 1'b0, 18'h0, 2'b00);
        exp_q.push_back('{op: ALU_XOR, rd: 4'd4, a: 32'hB0, b: 32'hB1});
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_2 got %b, required 0", in_ready); end
        drive(ALU_OR, 4'd5, 4'd1, 4'd2, 32'hC0, 32'hC1, 1'b0, 18'h0, 2'b00);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'hA0 || out_op !== ALU_SUB) begin
            errors++;
            $display("FAIL b2b_hold got v=%b op=%h a=%h, required v=1 op=1 a=000000a0", out_valid, out_op, out_a);
        end
        out_ready = 1'b1;
        wait_drain("b2b");
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        fwd_valid = 1'b1; fwd_rd = 4'd3; fwd_val = 32'd99;
        send(ALU_ADD, 4'd7, 4'd3, 4'd9, 32'd7, 32'd0, 1'b1, 18'h1, 2'b00, FWD ? 32'd99 : 32'd7, 32'd1);
        fwd_valid = 1'b0;
        wait_drain("fwd_capture");

        out_ready = 1'b0;
        send(ALU_AND, 4'd8, 4'd4, 4'd6, 32'd7, 32'd10, 1'b0, 18'h0, 2'b00, FWD ? 32'd99 : 32'd7, 32'd10);
        send(ALU_OR, 4'd9, 4'd1, 4'd5, 32'd1, 32'd20, 1'b0, 18'h0, 2'b00, 32'd1, FWD ? 32'd123 : 32'd20);
        fwd_valid = 1'b1; fwd_rd = 4'd4; fwd_val = 32'd99;
        @(posedge clk);
        #1 fwd_rd = 4'd5; fwd_val = 32'd123;
        @(posedge clk);
        #1 fwd_valid = 1'b0;
        checks++;
        if (out_a !== (FWD ? 32'd99 : 32'd7)) begin
            errors++;
            $display("FAIL fwd_held got a=%h, required %h", out_a, FWD ? 32'd99 : 32'd7);
        end
        out_ready = 1'b1;
        wait_drain("fwd_held");

        fwd_valid = 1'b1; fwd_rd = 4'd6; fwd_val = 32'd77;
        send(ALU_SLT, 4'd2, 4'd6, 4'd6, 32'd1, 32'd2, 1'b0, 18'h0, 2'b00,
             FWD ? 32'd77 : 32'd1, FWD ? 32'd77 : 32'd2);
        fwd_valid = 1'b0;
        wait_drain("fwd_dual");
    endtask

    task automatic test_imm_not_forwarded();
        out_ready = 1'b0;
        fwd_valid = 1'b1; fwd_rd = 4'd8; fwd_val = 32'd55;
        send(ALU_SLL, 4'd1, 4'd2, 4'd8, 32'd3, 32'd9, 1'b1, 18'h00042, 2'b01, 32'd3, 32'h42);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_b !== 32'h42 || out_a !== 32'd3) begin
            errors++;
            $display("FAIL imm_no_fwd got a=%h b=%h, required a=00000003 b=00000042", out_a, out_b);
        end
        fwd_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("imm_no_fwd");
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        drive(ALU_ADD, 4'd1, 4'd1, 4'd1, 32'h111, 32'h0, 1'b0, 18'h0, 2'b00);
        @(posedge clk);
        #1 drive(ALU_ADD, 4'd2, 4'd1, 4'd1, 32'h222, 32'h0, 1'b0, 18'h0, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup got rdy=%b v=%b, required rdy=0 v=1", in_ready, out_valid);
        end
        drive(ALU_ADD, 4'd3, 4'd1, 4'd1, 32'h333, 32'h0, 1'b0, 18'h0, 2'b00);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_result got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(ALU_MOV, 4'd5, 4'd1, 4'd1, 32'h555, 32'h0, 1'b1, 18'h7, 2'b00, 32'h555, 32'h7);
        wait_drain("flush");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(ALU_SRA, 4'd6, 4'd1, 4'd1, 32'h666, 32'h0, 1'b1, 18'h1, 2'b00, 32'h666, 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_a !== 32'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got v=%b a=%h rdy=%b, required v=0 a=0 rdy=0", out_valid, out_a, in_ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release got rdy=%b v=%b, required rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm_modes();
        test_back_to_back();
        test_forward();
        test_imm_not_forwarded();
        test_flush_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
